sw_alloc: RTL and testbench
===========================

# sw_alloc

Switch allocator for one router node. It sits between the per-port `rx` receive units and the output transmitters/crossbar. It collects each receiver's `sw_req`/`sw_chnl` packet-transfer request and arbitrates round-robin per output port. It holds the winner's `sw_gnt` high for the whole transfer, and drives the crossbar select plus a start pulse to the output transmitter. `sw_gnt` falls when that transmitter reports completion, which releases the receiver from its send-wait state.

## Interface
- `PORTS`, 5, number of input ports and number of output ports (equal counts).
- `PORT_BITS`, 8, width of each `sw_chnl` field (requested output port number).
- `SEL_BITS`, 3, width of each crossbar select field; must satisfy 2**SEL_BITS >= PORTS.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sw_req`  in  PORTS  per-input transfer request; bit i belongs to input i.
- `sw_chnl`  in  PORTS*PORT_BITS  requested output port; input i uses bits [i*PORT_BITS +: PORT_BITS].
- `sw_gnt`  out  PORTS  per-input grant, held for the duration of the transfer.
- `tx_start`  out  PORTS  one-cycle pulse per output: start sending the packet from `tx_sel`.
- `tx_sel`  out  PORTS*SEL_BITS  crossbar select; output o uses bits [o*SEL_BITS +: SEL_BITS] and carries the index of the granted input.
- `tx_done`  in  PORTS  per-output completion pulse from the transmitter.

## Operation
- There is one independent FSM per output o, with states `ST_IDLE` and `ST_BUSY`, and one round-robin pointer `last[o]`.
- Request matching: input i is a candidate for output o when `sw_req[i]`=1, its `sw_chnl` field equals o, and `sw_gnt[i]`=0.
  - A `sw_chnl` value >= PORTS matches no output. That request is never granted and is otherwise ignored.
- Arbitration runs only in `ST_IDLE`. Candidates are scanned in the order last[o]+1, last[o]+2, ... modulo PORTS, and the first candidate found wins.
- When output o grants in `ST_IDLE`, the following are registered:
  - `sw_gnt[winner]` <= 1;
  - `tx_start[o]` <= 1;
  - `tx_sel[o]` <= winner;
  - `last[o]` <= winner;
  - state <= `ST_BUSY`.
- In `ST_BUSY`:
  - `tx_start[o]` <= 0 every cycle, so the start is a single-cycle pulse.
  - If `tx_done[o]`=1, then `sw_gnt` for the input held in `tx_sel[o]` <= 0 and state <= `ST_IDLE`.
  - Requests to o are not evaluated while it is busy.
- `tx_done[o]` in `ST_IDLE` is ignored.
- `tx_sel[o]` keeps its last value after release.
- An input can hold at most one grant, because each input requests exactly one port.
- Different outputs grant in parallel in the same cycle without interaction.
- Reset sets:
  - all `sw_gnt`=0 and all `tx_start`=0;
  - all `tx_sel` fields=0;
  - all FSMs to `ST_IDLE`;
  - all `last[o]`=PORTS-1, so input 0 has first priority.
- Reset mid-transfer drops the grant immediately. The transmitter and receiver are reset by the same signal.

## Timing
- Grant latency: a request first visible in cycle N, with output o idle, gives `sw_gnt` and `tx_start` high in cycle N+1 (registered outputs).
- The receiver deasserts `sw_req` after seeing the grant. The stale `sw_req`=1 still present in cycle N+1 is harmless because o is `ST_BUSY` and the input is masked by its own `sw_gnt`.
- A `tx_done` pulse in cycle M gives `sw_gnt`=0 in cycle M+1. A `tx_done` in the same cycle as `tx_start` is accepted.
- The earliest re-grant of o is cycle M+2 (arbitration in the `ST_IDLE` cycle M+1). There is therefore at least one idle cycle between consecutive grants on one output.
- Outputs are registered, with no combinational path from the inputs to `sw_gnt`, `tx_start` or `tx_sel`.

## Test plan
- Single request: after reset, input 2 requests port 4 (`sw_req`=00100, field 2=4).
  - Required: one cycle later `sw_gnt`=00100, `tx_start`=10000 for exactly one cycle, `tx_sel[4]`=2.
  - Drop `sw_req`; `tx_done[4]` pulsed 5 cycles later -> `sw_gnt`=0 the next cycle.
- Round-robin fairness: inputs 0, 1 and 3 all request port 1 continuously (re-raise after each release).
  - Required: grant order 0, 1, 3, 0, 1, 3.
  - Required: each grant follows the previous `tx_done` by exactly 2 cycles.
- Parallel outputs: input 0 requests port 2 and input 1 requests port 3 in the same cycle.
  - Required: both grants and both `tx_start` pulses in the same cycle.
  - `tx_done[3]` before `tx_done[2]` -> the grants release independently.
- Boundaries: invalid port (field=7) with `sw_req` high -> never granted, no `tx_start`.
  - `tx_done` while idle -> no change.
  - `tx_done` in the `tx_start` cycle -> `sw_gnt` drops the following cycle.
- Reset mid-transfer: assert `reset` while output 1 is busy granting input 3.
  - Required: `sw_gnt`=0, `tx_start`=0 and all `tx_sel`=0 immediately.
  - After release, a request from input 4 to port 1 is granted normally.
  - Priority is restored: inputs 0 and 4 requesting port 1 together -> input 0 wins.

Source files
------------

// File: rtl/sw_alloc_if.sv
// Switch allocator handshake bundle.
// Groups the receiver request/grant signals and the transmitter
// start/select/done signals of one router node.
//   sw_req   : per-input transfer request
//   sw_chnl  : per-input requested output port, PORT_BITS per input
//   sw_gnt   : per-input grant, held for the whole transfer
//   tx_start : per-output one-cycle start pulse
//   tx_sel   : per-output crossbar select, SEL_BITS per output
//   tx_done  : per-output completion pulse
// Modports: master = receivers/transmitters side, slave = allocator.
interface sw_alloc_if #(
    parameter int PORTS     = 5,
    parameter int PORT_BITS = 8,
    parameter int SEL_BITS  = 3
);
    logic [PORTS-1:0]           sw_req;
    logic [PORTS*PORT_BITS-1:0] sw_chnl;
    logic [PORTS-1:0]           sw_gnt;
    logic [PORTS-1:0]           tx_start;
    logic [PORTS*SEL_BITS-1:0]  tx_sel;
    logic [PORTS-1:0]           tx_done;

    modport master (
        output sw_req, sw_chnl, tx_done,
        input  sw_gnt, tx_start, tx_sel
    );

    modport slave (
        input  sw_req, sw_chnl, tx_done,
        output sw_gnt, tx_start, tx_sel
    );
endinterface

// File: rtl/sw_alloc.sv
// Switch allocator for one router node.
// One round-robin arbiter/FSM per output port picks among the inputs
// requesting that port, grants it for the whole packet transfer and
// releases the grant on the transmitter's done pulse.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : sw_alloc_if.slave (sw_req/sw_chnl/tx_done in,
//           sw_gnt/tx_start/tx_sel out); all outputs registered.

// Per-output arbiter lane: state, round-robin pointer, start pulse and
// crossbar select. set/clr tell the top which input grant to raise or drop.
module sw_alloc_out #(
    parameter int PORTS    = 5,
    parameter int SEL_BITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PORTS-1:0]    cand,
    input  logic                done,
    output logic                start,
    output logic [SEL_BITS-1:0] sel,
    output logic [PORTS-1:0]    set,
    output logic [PORTS-1:0]    clr
);
    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t              state;
    logic [SEL_BITS-1:0] last;
    logic                found;
    logic [SEL_BITS-1:0] win;
    logic [SEL_BITS:0]   idx;

    // Scan last+1, last+2, ... modulo PORTS; first candidate wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= PORTS; k++) begin
            idx = {1'b0, last} + (SEL_BITS+1)'(k);
            if (idx >= (SEL_BITS+1)'(PORTS))
                idx = idx - (SEL_BITS+1)'(PORTS);
            if (!found && cand[idx[SEL_BITS-1:0]]) begin
                found = 1'b1;
                win   = idx[SEL_BITS-1:0];
            end
        end
    end

    always_comb begin
        set = '0;
        clr = '0;
        if (state == ST_IDLE && found)
            set = PORTS'(1) << win;
        if (state == ST_BUSY && done)
            clr = PORTS'(1) << sel;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            start <= 1'b0;
            sel   <= '0;
            last  <= SEL_BITS'(PORTS-1);   // input 0 gets first priority
        end else begin
            case (state)
                ST_IDLE: begin
                    start <= 1'b0;
                    if (found) begin
                        start <= 1'b1;
                        sel   <= win;
                        last  <= win;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    start <= 1'b0;
                    if (done)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

module sw_alloc #(
    parameter int PORTS     = 5,
    parameter int PORT_BITS = 8,
    parameter int SEL_BITS  = 3
) (
    input  logic     clk,
    input  logic     reset,
    sw_alloc_if.slave bus
);
    logic [PORTS-1:0][PORTS-1:0] cand;   // [output][input]
    logic [PORTS-1:0][PORTS-1:0] set;
    logic [PORTS-1:0][PORTS-1:0] clr;
    logic [PORTS-1:0]            set_any;
    logic [PORTS-1:0]            clr_any;
    logic [PORTS-1:0]            gnt_q;
    logic [PORTS-1:0]            start_v;
    logic [PORTS*SEL_BITS-1:0]   sel_v;

    // Out-of-range sw_chnl values never equal any o, so they are ignored.
    // Inputs already granted are masked so a stale request cannot re-win.
    always_comb begin
        cand = '0;
        for (int o = 0; o < PORTS; o++)
            for (int i = 0; i < PORTS; i++)
                cand[o][i] = bus.sw_req[i] && !gnt_q[i] &&
                             (bus.sw_chnl[i*PORT_BITS +: PORT_BITS] == PORT_BITS'(o));
    end

    always_comb begin
        set_any = '0;
        clr_any = '0;
        for (int o = 0; o < PORTS; o++) begin
            set_any = set_any | set[o];
            clr_any = clr_any | clr[o];
        end
    end

    // An input requests one port only, so set and clr never hit the same bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) gnt_q <= '0;
        else       gnt_q <= (gnt_q & ~clr_any) | set_any;
    end

    for (genvar o = 0; o < PORTS; o++) begin : g_out
        sw_alloc_out #(.PORTS(PORTS), .SEL_BITS(SEL_BITS)) u_out (
            .clk   (clk),
            .reset (reset),
            .cand  (cand[o]),
            .done  (bus.tx_done[o]),
            .start (start_v[o]),
            .sel   (sel_v[o*SEL_BITS +: SEL_BITS]),
            .set   (set[o]),
            .clr   (clr[o])
        );
    end

    assign bus.sw_gnt   = gnt_q;
    assign bus.tx_start = start_v;
    assign bus.tx_sel   = sel_v;
endmodule

// File: tb/tb_sw_alloc.sv
// Directed bench for sw_alloc: expected outputs are queued with each
// stimulus step and compared after the following clock edge.
module tb_sw_alloc;
    logic clk;
    logic reset;

    sw_alloc_if #(.PORTS(5), .PORT_BITS(8), .SEL_BITS(3)) bus ();

    sw_alloc #(.PORTS(5), .PORT_BITS(8), .SEL_BITS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [4:0]  gnt;
        logic [4:0]  start;
        logic [14:0] sel;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [14:0] sel_m;

    task automatic push(input string tag, input logic [4:0] g,
                        input logic [4:0] s, input logic [14:0] sl);
        exp_t e;
        e.tag = tag; e.gnt = g; e.start = s; e.sel = sl;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_assert++;
            assert (bus.sw_gnt === e.gnt) else begin
                n_fail++;
                $error("FAIL %s sw_gnt: observed %b expected %b", e.tag, bus.sw_gnt, e.gnt);
            end
            n_assert++;
            assert (bus.tx_start === e.start) else begin
                n_fail++;
                $error("FAIL %s tx_start: observed %b expected %b", e.tag, bus.tx_start, e.start);
            end
            n_assert++;
            assert (bus.tx_sel === e.sel) else begin
                n_fail++;
                $error("FAIL %s tx_sel: observed %h expected %h", e.tag, bus.tx_sel, e.sel);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_now();
    endtask

    task automatic set_sel(input int o, input int v);
        sel_m[o*3 +: 3] = 3'(v);
    endtask

    task automatic set_chnl(input int i, input int v);
        bus.sw_chnl[i*8 +: 8] = 8'(v);
    endtask

    int order[6] = '{0, 1, 3, 0, 1, 3};

    initial begin
        reset       = 1'b1;
        bus.sw_req  = '0;
        bus.sw_chnl = '0;
        bus.tx_done = '0;
        sel_m       = '0;

        // reset state
        push("reset", 5'b00000, 5'b00000, 15'h0);
        tick();
        tick();
        reset = 1'b0;

        // single request: input 2 -> port 4
        set_chnl(2, 4);
        bus.sw_req = 5'b00100;
        set_sel(4, 2);
        push("single_gnt", 5'b00100, 5'b10000, sel_m);
        tick();
        bus.sw_req = 5'b00000;
        push("single_pulse", 5'b00100, 5'b00000, sel_m);
        tick();
        for (int c = 0; c < 4; c++) begin
            push("single_hold", 5'b00100, 5'b00000, sel_m);
            tick();
        end
        bus.tx_done = 5'b10000;
        push("single_release", 5'b00000, 5'b00000, sel_m);
        tick();
        bus.tx_done = 5'b00000;

        // round robin: inputs 0,1,3 all on port 1, kept requesting
        bus.sw_chnl = '0;
        set_chnl(0, 1); set_chnl(1, 1); set_chnl(3, 1);
        bus.sw_req = 5'b01011;
        for (int r = 0; r < 6; r++) begin
            set_sel(1, order[r]);
            push($sformatf("rr_gnt%0d", r), 5'(1 << order[r]), 5'b00010, sel_m);
            tick();
            push($sformatf("rr_pulse%0d", r), 5'(1 << order[r]), 5'b00000, sel_m);
            tick();
            bus.tx_done = 5'b00010;
            push($sformatf("rr_release%0d", r), 5'b00000, 5'b00000, sel_m);
            tick();
            bus.tx_done = 5'b00000;
        end
        bus.sw_req = 5'b00000;

        // parallel outputs: 0 -> 2 and 1 -> 3 in the same cycle
        bus.sw_chnl = '0;
        set_chnl(0, 2); set_chnl(1, 3);
        bus.sw_req = 5'b00011;
        set_sel(2, 0); set_sel(3, 1);
        push("par_gnt", 5'b00011, 5'b01100, sel_m);
        tick();
        bus.sw_req = 5'b00000;
        push("par_pulse", 5'b00011, 5'b00000, sel_m);
        tick();
        bus.tx_done = 5'b01000;
        push("par_rel3", 5'b00001, 5'b00000, sel_m);
        tick();
        bus.tx_done = 5'b00000;
        push("par_hold2", 5'b00001, 5'b00000, sel_m);
        tick();
        bus.tx_done = 5'b00100;
        push("par_rel2", 5'b00000, 5'b00000, sel_m);
        tick();
        bus.tx_done = 5'b00000;

        // invalid port field never granted
        bus.sw_chnl = '0;
        set_chnl(0, 7);
        bus.sw_req = 5'b00001;
        for (int c = 0; c < 3; c++) begin
            push("invalid_port", 5'b00000, 5'b00000, sel_m);
            tick();
        end
        bus.sw_req = 5'b00000;

        // tx_done while idle is ignored
        bus.tx_done = 5'b11111;
        push("done_idle", 5'b00000, 5'b00000, sel_m);
        tick();
        bus.tx_done = 5'b00000;
        push("done_idle_after", 5'b00000, 5'b00000, sel_m);
        tick();

        // tx_done in the tx_start cycle: input 4 -> port 0
        bus.sw_chnl = '0;
        set_chnl(4, 0);
        bus.sw_req = 5'b10000;
        set_sel(0, 4);
        push("early_gnt", 5'b10000, 5'b00001, sel_m);
        tick();
        bus.sw_req  = 5'b00000;
        bus.tx_done = 5'b00001;
        push("early_release", 5'b00000, 5'b00000, sel_m);
        tick();
        bus.tx_done = 5'b00000;

        // reset mid-transfer: input 3 busy on port 1
        bus.sw_chnl = '0;
        set_chnl(3, 1);
        bus.sw_req = 5'b01000;
        set_sel(1, 3);
        push("busy_gnt", 5'b01000, 5'b00010, sel_m);
        tick();
        bus.sw_req = 5'b00000;
        push("busy_hold", 5'b01000, 5'b00000, sel_m);
        tick();
        reset = 1'b1;
        #1;
        sel_m = '0;
        push("async_reset", 5'b00000, 5'b00000, sel_m);
        check_now();
        push("reset_held", 5'b00000, 5'b00000, sel_m);
        tick();
        reset = 1'b0;

        // priority restored: inputs 0 and 4 on port 1, input 0 wins
        bus.sw_chnl = '0;
        set_chnl(0, 1); set_chnl(4, 1);
        bus.sw_req = 5'b10001;
        set_sel(1, 0);
        push("prio_gnt", 5'b00001, 5'b00010, sel_m);
        tick();
        bus.sw_req  = 5'b10000;
        bus.tx_done = 5'b00010;
        push("prio_release", 5'b00000, 5'b00000, sel_m);
        tick();
        bus.tx_done = 5'b00000;
        set_sel(1, 4);
        push("post_reset_gnt4", 5'b10000, 5'b00010, sel_m);
        tick();
        bus.sw_req  = 5'b00000;
        bus.tx_done = 5'b00010;
        push("post_reset_rel4", 5'b00000, 5'b00000, sel_m);
        tick();
        bus.tx_done = 5'b00000;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
